// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame definitions for the RX and TX sides
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic logic odd_par(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer with delayed copy and rising-edge flag
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_s,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= IDLE_LEVEL;
            r_sync   <= IDLE_LEVEL;
            r_sync_d <= IDLE_LEVEL;
        end else begin
            r_meta   <= i_rx;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_s    = r_sync;
    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampling UART receiver with majority vote and one-byte holding register
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int         H       = CLKS_PER_BIT / 2;
    localparam logic [7:0] TC_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] TC_VM1  = 8'(H - 1);
    localparam logic [7:0] TC_V0   = 8'(H);
    localparam logic [7:0] TC_VP1  = 8'(H + 1);

    logic w_s;
    logic w_rise;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (rx_in),
        .o_s    (w_s),
        .o_rise (w_rise)
    );

    rx_state_t              r_state;
    rx_state_t              w_next;
    logic [7:0]             r_tc;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_v0;
    logic                   r_v1;
    logic                   r_par;
    logic                   r_done;
    logic                   r_stop_vote;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_vote_pt;
    logic w_vote;

    assign w_vote_pt = (r_tc == TC_VP1);
    // Third sample is the live synchronized line at the vote point itself.
    assign w_vote    = (r_v0 & r_v1) | (r_v0 & w_s) | (r_v1 & w_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_next = START;
            START:   if (w_vote_pt) w_next = (w_vote == START_LEVEL) ? DATA : IDLE;
            DATA:    if (w_vote_pt && (r_bit_idx == 3'(DATA_BITS - 1))) w_next = PARITY;
            PARITY:  if (w_vote_pt) w_next = STOP;
            STOP:    if (w_vote_pt) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tc        <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_par       <= 1'b0;
            r_done      <= 1'b0;
            r_stop_vote <= 1'b0;
        end else begin
            if (r_state == IDLE)      r_tc <= w_rise ? 8'd1 : 8'd0;
            else if (r_tc == TC_LAST) r_tc <= 8'd0;
            else                      r_tc <= r_tc + 8'd1;

            if (r_tc == TC_VM1) r_v0 <= w_s;
            if (r_tc == TC_V0)  r_v1 <= w_s;

            if (w_vote_pt && r_state == START) r_bit_idx <= '0;
            if (w_vote_pt && r_state == DATA) begin
                r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_vote_pt && r_state == PARITY) r_par <= w_vote;

            r_done <= w_vote_pt && (r_state == STOP);
            if (w_vote_pt && r_state == STOP) r_stop_vote <= w_vote;
        end
    end

    // A completion overrides a same-cycle transfer; with a full, unread buffer it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shift;
                    r_parity_err <= (r_par != odd_par(r_shift));
                    r_frame_err  <= (r_stop_vote != STOP_LEVEL);
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled at 16 and 4 clocks per bit
module tb_uart_rx_oversampled;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       pe_a, pe_b, fe_a, fe_b;
    logic       ovr_a, ovr_b;
    logic       busy_a, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ovr_cnt_a = 0;
    int   ovr_snap;
    int   lat;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.CLKS_PER_BIT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_oversampled #(.CLKS_PER_BIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ovr_a) ovr_cnt_a++;
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_a_unexpected actual=0x%0h expected=none", data_a);
                end else begin
                    e_a = q_a.pop_front();
                    check("sb_a_data", {24'd0, data_a}, {24'd0, e_a.d});
                    check("sb_a_parity_err", {31'd0, pe_a}, {31'd0, e_a.pe});
                    check("sb_a_frame_err", {31'd0, fe_a}, {31'd0, e_a.fe});
                end
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_b_unexpected actual=0x%0h expected=none", data_b);
                end else begin
                    e_b = q_b.pop_front();
                    check("sb_b_data", {24'd0, data_b}, {24'd0, e_b.d});
                    check("sb_b_errs", {30'd0, pe_b, fe_b}, {30'd0, e_b.pe, e_b.fe});
                end
            end
        end
    end

    task automatic drive(input int which, input logic v, input int n);
        if (n <= 0) return;
        if (which == 0) rx_a = v;
        else            rx_b = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic p, input logic stp,
                              input int cpb, input int start_len, input int gbit, input int goff,
                              input int tail);
        logic [10:0] bits;
        int          len;
        bits = {stp, p, d, 1'b1};
        for (int i = 0; i < 11; i++) begin
            len = (i == 0) ? start_len : cpb;
            if (i == gbit) begin
                drive(which, bits[i], goff);
                drive(which, ~bits[i], 1);
                drive(which, bits[i], len - goff - 1);
            end else begin
                drive(which, bits[i], len);
            end
        end
        drive(which, 1'b0, tail);
    endtask

    task automatic tx_a(input logic [7:0] d, input logic p, input logic stp, input int tail);
        send_frame(0, d, p, stp, 16, 16, -1, 0, tail);
    endtask

    task automatic drain_a();
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d);
        exp_t e;
        e.d = d; e.pe = 1'b0; e.fe = 1'b0;
        q_b.push_back(e);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; rx_a = 1'b0; rx_b = 1'b0; ready_a = 1'b0; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {20'd0, data_a, valid_a, pe_a, fe_a, ovr_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        rst_n = 1'b1;
        drive(0, 1'b0, 8);

        // 1: clean byte, latency, handshake
        push_a(8'hA5, 1'b0, 1'b0);
        lat = 0;
        fork
            tx_a(8'hA5, 1'b1, 1'b1, 16);
            begin
                while (!valid_a && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check("latency", lat, 173);
            end
        join
        check("t1_valid", {31'd0, valid_a}, 32'd1);
        check("t1_data", {24'd0, data_a}, 32'hA5);
        check("t1_flags", {30'd0, pe_a, fe_a}, 32'd0);
        drain_a();
        check("t1_valid_drop", {31'd0, valid_a}, 32'd0);

        // 2: parity error, stuck-high line, framing error
        push_a(8'h3C, 1'b1, 1'b0);
        tx_a(8'h3C, 1'b0, 1'b1, 0);
        drive(0, 1'b1, 48);
        check("t2_stuck_busy", {31'd0, busy_a}, 32'd0);
        check("t2_parity", {23'd0, data_a, pe_a}, {23'd0, 8'h3C, 1'b1});
        drive(0, 1'b0, 16);
        check("t2_stuck_busy2", {31'd0, busy_a}, 32'd0);
        drain_a();
        push_a(8'h00, 1'b0, 1'b1);
        tx_a(8'h00, 1'b1, 1'b0, 16);
        check("t2_frame", {22'd0, data_a, pe_a, fe_a}, {22'd0, 8'h00, 1'b0, 1'b1});
        drain_a();

        // 3: glitch rejection
        drive(0, 1'b1, 1);
        drive(0, 1'b0, 2);
        check("t3_busy_rise", {31'd0, busy_a}, 32'd1);
        drive(0, 1'b0, 30);
        check("t3_glitch", {30'd0, busy_a, valid_a}, 32'd0);
        drive(0, 1'b1, 5);
        drive(0, 1'b0, 40);
        check("t3_pulse", {30'd0, busy_a, valid_a}, 32'd0);

        // 4: overrun, then completion coinciding with a transfer
        push_a(8'h11, 1'b0, 1'b0);
        ovr_snap = ovr_cnt_a;
        tx_a(8'h11, 1'b1, 1'b1, 16);
        tx_a(8'h22, 1'b1, 1'b1, 16);
        check("t4_kept", {23'd0, data_a, valid_a}, {23'd0, 8'h11, 1'b1});
        check("t4_overrun", ovr_cnt_a - ovr_snap, 1);
        drain_a();
        push_a(8'h11, 1'b0, 1'b0);
        tx_a(8'h11, 1'b1, 1'b1, 16);
        push_a(8'h22, 1'b0, 1'b0);
        ovr_snap = ovr_cnt_a;
        fork
            tx_a(8'h22, 1'b1, 1'b1, 16);
            begin
                repeat (172) @(posedge clk);
                #1;
                ready_a = 1'b1;
                @(posedge clk);
                #1;
                ready_a = 1'b0;
            end
        join
        check("t4_replaced", {23'd0, data_a, valid_a}, {23'd0, 8'h22, 1'b1});
        check("t4_no_overrun", ovr_cnt_a - ovr_snap, 0);
        drain_a();

        // 5: mid-bit glitch on D0, and skewed frames at 4 clocks per bit
        push_a(8'h81, 1'b0, 1'b0);
        send_frame(0, 8'h81, 1'b1, 1'b1, 16, 16, 1, 8, 16);
        check("t5_glitch", {22'd0, data_a, pe_a, fe_a}, {22'd0, 8'h81, 2'b00});
        drain_a();
        push_b(8'h81);
        send_frame(1, 8'h81, 1'b1, 1'b1, 4, 5, -1, 0, 4);
        push_b(8'h81);
        send_frame(1, 8'h81, 1'b1, 1'b1, 4, 3, -1, 0, 4);
        drive(1, 1'b0, 8);
        check("t5_b_consumed", q_b.size(), 0);

        // 6: reset mid-frame with a full buffer
        tx_a(8'h77, 1'b1, 1'b1, 16);
        check("t6_pre", {23'd0, data_a, valid_a}, {23'd0, 8'h77, 1'b1});
        drive(0, 1'b1, 16);
        drive(0, 1'b1, 40);
        check("t6_mid_busy", {31'd0, busy_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_out", {20'd0, data_a, valid_a, pe_a, fe_a, ovr_a}, 32'd0);
        check("t6_reset_busy", {31'd0, busy_a}, 32'd0);
        rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1'b0, 16);
        push_a(8'h5A, 1'b0, 1'b0);
        tx_a(8'h5A, 1'b1, 1'b1, 16);
        check("t6_after", {22'd0, data_a, pe_a, fe_a}, {22'd0, 8'h5A, 2'b00});
        drain_a();
        drive(0, 1'b0, 4);
        check("sb_a_empty", q_a.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
